// File: rtl/mem_arbiter_if.sv
// Signal bundle for the shared-RAM arbiter: fetch port, data port and RAM port.
// The slave modport is the arbiter's view; master is the requesters plus the RAM.
interface mem_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ready;
  logic        d_ren;
  logic        d_wen;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_ren;
  logic        ram_wen;
  logic [31:0] ram_rdata;
  logic        ram_busy;
  logic        err;

  modport slave (
    input  i_req, i_addr, d_ren, d_wen, d_addr, d_wdata, ram_rdata, ram_busy,
    output i_rdata, i_ready, d_rdata, d_ready, ram_addr, ram_wdata, ram_ren, ram_wen, err
  );

  modport master (
    output i_req, i_addr, d_ren, d_wen, d_addr, d_wdata, ram_rdata, ram_busy,
    input  i_rdata, i_ready, d_rdata, d_ready, ram_addr, ram_wdata, ram_ren, ram_wen, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one RAM between fetch and data ports, one access in flight.
// Request-to-ready is 3 cycles plus ram_busy stall cycles; requesters hold until ready, a stuck RAM aborts after TIMEOUT.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          nrst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  typedef enum logic [1:0] {K_IRD, K_DRD, K_DWR} kind_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  kind_t       kind_q, kind_d;
  logic        last_d_q, last_d_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;

  logic        i_pend;
  logic        d_pend;
  logic        grant_d;

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      state_q   <= IDLE;
      kind_q    <= K_IRD;
      last_d_q  <= 1'b1;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      kind_q    <= kind_d;
      last_d_q  <= last_d_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    last_d_d  = last_d_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    i_pend    = bus.i_req;
    d_pend    = bus.d_ren | bus.d_wen;
    grant_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_pend || d_pend) begin
          // on a tie the side that did not win last time goes first
          grant_d  = d_pend && (!i_pend || !last_d_q);
          last_d_d = grant_d;
          if (grant_d) begin
            kind_d  = bus.d_wen ? K_DWR : K_DRD;
            addr_d  = bus.d_addr;
            wdata_d = bus.d_wdata;
          end else begin
            kind_d  = K_IRD;
            addr_d  = bus.i_addr;
            wdata_d = '0;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (!bus.ram_busy) begin
          if (kind_q == K_IRD) begin
            i_rdata_d = bus.ram_rdata;
          end else if (kind_q == K_DRD) begin
            d_rdata_d = bus.ram_rdata;
          end
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          err_d = 1'b1;
          if (kind_q == K_IRD) begin
            i_rdata_d = '0;
          end else begin
            d_rdata_d = '0;
          end
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.i_ready   = (state_q == DONE) && (kind_q == K_IRD);
  assign bus.d_ready   = (state_q == DONE) && (kind_q != K_IRD);
  assign bus.ram_ren   = (state_q == ISSUE) && (kind_q != K_DWR);
  assign bus.ram_wen   = (state_q == ISSUE) && (kind_q == K_DWR);
  assign bus.ram_addr  = (state_q == ISSUE || state_q == WAIT) ? addr_q : '0;
  assign bus.ram_wdata = (state_q == ISSUE || state_q == WAIT) ? wdata_q : '0;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected strobes and completions are queued at drive time
// and matched against the DUT at the falling clock edge.
module tb_mem_arbiter;

  logic clk;
  logic nrst;
  mem_arbiter_if bus();

  mem_arbiter #(.TIMEOUT(255)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    int          t0;
    int          lat;
  } iss_t;

  typedef struct {
    logic        is_d;
    logic [31:0] ir;
    logic [31:0] dr;
    logic        er;
    int          t0;
    int          lat;
  } exp_t;

  iss_t        iq[$];
  exp_t        eq[$];
  iss_t        mon_s;
  exp_t        mon_e;
  logic [31:0] i_hold;
  logic [31:0] d_hold;
  logic        err_m;
  int          cyc;
  int          cfg_busy;
  int          ram_k;
  logic        ram_act;
  int          total;
  int          bad;
  logic [31:0] r_addr;
  logic [31:0] r_wd;
  int          r_busy;
  int          r_kind;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    if (a == 32'h40) return 32'h0050_0093;
    return (a ^ 32'h5EED_0000) + 32'h11;
  endfunction

  // Push expected RAM strobe and completion for one access, updating the rdata/err model.
  task automatic exp_acc(input logic is_d, input logic wr, input logic [31:0] a,
                         input logic [31:0] wd, input int slat, input int lat, input logic to);
    iss_t s;
    exp_t e;
    s.addr = a; s.wdata = wd; s.wr = wr; s.t0 = cyc; s.lat = slat;
    iq.push_back(s);
    if (to) err_m = 1'b1;
    if (!wr) begin
      if (is_d) d_hold = to ? 32'h0 : rd_fn(a);
      else      i_hold = to ? 32'h0 : rd_fn(a);
    end
    e.is_d = is_d; e.ir = i_hold; e.dr = d_hold; e.er = err_m; e.t0 = cyc; e.lat = lat;
    eq.push_back(e);
  endtask

  // Requesters drop their request on the falling edge where their ready is seen.
  task automatic wait_all(input int max);
    int n;
    n = 0;
    while ((eq.size() != 0 || bus.i_req || bus.d_ren || bus.d_wen) && n < max) begin
      @(negedge clk);
      n++;
      if (bus.i_ready) bus.i_req = 1'b0;
      if (bus.d_ready) begin
        bus.d_ren = 1'b0;
        bus.d_wen = 1'b0;
      end
    end
    chk("done_in_time", 32'(n < max), 32'd1);
    if (n >= max) begin
      eq.delete();
      iq.delete();
      bus.i_req = 1'b0; bus.d_ren = 1'b0; bus.d_wen = 1'b0;
    end
    @(negedge clk);
    chk("idle_ram_addr", bus.ram_addr, 32'h0);
    chk("idle_strobes", 32'({bus.ram_ren, bus.ram_wen}), 32'd0);
  endtask

  // RAM model: after a strobe, busy for cfg_busy WAIT cycles, data follows the address.
  initial begin
    bus.ram_busy  = 1'b0;
    bus.ram_rdata = 32'h0;
    ram_act = 1'b0;
    ram_k   = 0;
    forever begin
      @(negedge clk);
      bus.ram_rdata = rd_fn(bus.ram_addr);
      if (nrst) begin
        ram_act = 1'b0;
        bus.ram_busy = 1'b0;
      end else if (bus.ram_ren || bus.ram_wen) begin
        ram_act = 1'b1;
        ram_k = 0;
        bus.ram_busy = (cfg_busy > 0);
      end else if (ram_act) begin
        bus.ram_busy = (ram_k < cfg_busy);
        ram_k++;
        if (!bus.ram_busy) ram_act = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!nrst) begin
        if (bus.ram_ren || bus.ram_wen) begin
          if (iq.size() == 0) begin
            chk("unexpected_strobe", 32'd1, 32'd0);
          end else begin
            mon_s = iq.pop_front();
            chk("ram_addr", bus.ram_addr, mon_s.addr);
            chk("strobe_kind", 32'({bus.ram_ren, bus.ram_wen}), 32'(mon_s.wr ? 2'b01 : 2'b10));
            if (mon_s.wr) chk("ram_wdata", bus.ram_wdata, mon_s.wdata);
            chk("issue_lat", 32'(cyc - mon_s.t0), 32'(mon_s.lat));
          end
        end
        if (bus.i_ready || bus.d_ready) begin
          if (eq.size() == 0) begin
            chk("unexpected_ready", 32'd1, 32'd0);
          end else begin
            mon_e = eq.pop_front();
            chk("ready_side", 32'({bus.i_ready, bus.d_ready}), 32'(mon_e.is_d ? 2'b01 : 2'b10));
            chk("i_rdata", bus.i_rdata, mon_e.ir);
            chk("d_rdata", bus.d_rdata, mon_e.dr);
            chk("err", 32'(bus.err), 32'(mon_e.er));
            chk("ready_lat", 32'(cyc - mon_e.t0), 32'(mon_e.lat));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0;
    i_hold = 0; d_hold = 0; err_m = 0; cfg_busy = 0;
    nrst = 1'b1;
    bus.i_req = 1'b0; bus.i_addr = 32'h0;
    bus.d_ren = 1'b0; bus.d_wen = 1'b0; bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
    #1;
    chk("rst_ctrl", 32'({bus.i_ready, bus.d_ready, bus.ram_ren, bus.ram_wen, bus.err}), 32'd0);
    chk("rst_i_rdata", bus.i_rdata, 32'h0);
    chk("rst_d_rdata", bus.d_rdata, 32'h0);
    chk("rst_ram_addr", bus.ram_addr, 32'h0);
    chk("rst_ram_wdata", bus.ram_wdata, 32'h0);
    repeat (3) @(negedge clk);
    nrst = 1'b0;
    @(negedge clk);

    // tie straight out of reset: fetch wins, then the data read
    cfg_busy = 0;
    bus.i_req = 1'b1; bus.i_addr = 32'h100;
    bus.d_ren = 1'b1; bus.d_addr = 32'h200;
    exp_acc(1'b0, 1'b0, 32'h100, 32'h0, 1, 3, 1'b0);
    exp_acc(1'b1, 1'b0, 32'h200, 32'h0, 5, 7, 1'b0);
    wait_all(40);

    // minimum-latency fetch
    bus.i_req = 1'b1; bus.i_addr = 32'h40;
    exp_acc(1'b0, 1'b0, 32'h40, 32'h0, 1, 3, 1'b0);
    wait_all(40);

    // last grant was fetch, so a tie now goes to data
    bus.i_req = 1'b1; bus.i_addr = 32'h300;
    bus.d_ren = 1'b1; bus.d_addr = 32'h400;
    exp_acc(1'b1, 1'b0, 32'h400, 32'h0, 1, 3, 1'b0);
    exp_acc(1'b0, 1'b0, 32'h300, 32'h0, 5, 7, 1'b0);
    wait_all(40);

    // write with four busy cycles
    cfg_busy = 4;
    bus.d_wen = 1'b1; bus.d_addr = 32'h80; bus.d_wdata = 32'hCAFE_F00D;
    exp_acc(1'b1, 1'b1, 32'h80, 32'hCAFE_F00D, 1, 7, 1'b0);
    wait_all(40);

    // read and write together behave as a write
    cfg_busy = 1;
    bus.d_ren = 1'b1; bus.d_wen = 1'b1; bus.d_addr = 32'h84; bus.d_wdata = 32'h1234_5678;
    exp_acc(1'b1, 1'b1, 32'h84, 32'h1234_5678, 1, 4, 1'b0);
    wait_all(40);

    // last grant was data, so a tie goes to fetch
    cfg_busy = 0;
    bus.i_req = 1'b1; bus.i_addr = 32'h500;
    bus.d_ren = 1'b1; bus.d_addr = 32'h600;
    exp_acc(1'b0, 1'b0, 32'h500, 32'h0, 1, 3, 1'b0);
    exp_acc(1'b1, 1'b0, 32'h600, 32'h0, 5, 7, 1'b0);
    wait_all(40);

    for (int n = 0; n < 8; n++) begin
      r_addr = $urandom() & 32'h0000_FFFC;
      r_wd   = $urandom();
      r_busy = int'($urandom_range(0, 3));
      r_kind = int'($urandom_range(0, 2));
      cfg_busy = r_busy;
      if (r_kind == 0) begin
        bus.i_req = 1'b1; bus.i_addr = r_addr;
        exp_acc(1'b0, 1'b0, r_addr, 32'h0, 1, 3 + r_busy, 1'b0);
      end else begin
        bus.d_addr = r_addr; bus.d_wdata = r_wd;
        bus.d_ren = (r_kind == 1); bus.d_wen = (r_kind == 2);
        exp_acc(1'b1, r_kind == 2, r_addr, r_wd, 1, 3 + r_busy, 1'b0);
      end
      wait_all(40);
    end

    // RAM never frees up: abort after 255 WAIT cycles
    cfg_busy = 1000;
    bus.i_req = 1'b1; bus.i_addr = 32'h700;
    exp_acc(1'b0, 1'b0, 32'h700, 32'h0, 1, 257, 1'b1);
    wait_all(400);

    // service continues after the abort, err stays set
    cfg_busy = 0;
    bus.i_req = 1'b1; bus.i_addr = 32'h40;
    exp_acc(1'b0, 1'b0, 32'h40, 32'h0, 1, 3, 1'b0);
    wait_all(40);

    // reset in the middle of a data read's WAIT phase
    cfg_busy = 50;
    bus.d_ren = 1'b1; bus.d_addr = 32'h900;
    exp_acc(1'b1, 1'b0, 32'h900, 32'h0, 1, 55, 1'b0);
    repeat (6) @(negedge clk);
    #2;
    nrst = 1'b1;
    #1;
    chk("mid_rst_ctrl", 32'({bus.i_ready, bus.d_ready, bus.ram_ren, bus.ram_wen, bus.err}), 32'd0);
    chk("mid_rst_i_rdata", bus.i_rdata, 32'h0);
    chk("mid_rst_d_rdata", bus.d_rdata, 32'h0);
    chk("mid_rst_ram_addr", bus.ram_addr, 32'h0);
    eq.delete();
    iq.delete();
    i_hold = 0; d_hold = 0; err_m = 0;
    cfg_busy = 0;
    repeat (2) @(negedge clk);
    chk("rst_hold_d_ready", 32'(bus.d_ready), 32'd0);
    nrst = 1'b0;
    exp_acc(1'b1, 1'b0, 32'h900, 32'h0, 1, 3, 1'b0);
    wait_all(40);

    chk("leftover", 32'(eq.size() + iq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, max ram_busy wait cycles before an access is aborted (1..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 nrst  input  1  reset, asynchronous and active-high (1 = reset asserted, despite the name).
REQ-004 i_req  input  1  instruction-fetch request; held by requester until i_ready.
REQ-005 i_addr  input  32  fetch address.
REQ-006 i_rdata  output  32  fetched word, valid while i_ready=1.
REQ-007 i_ready  output  1  one-cycle fetch-complete pulse.
REQ-008 d_ren  input  1  data-read request; held until d_ready.
REQ-009 d_wen  input  1  data-write request; held until d_ready.
REQ-010 d_addr  input  32  data address.
REQ-011 d_wdata  input  32  store data.
REQ-012 d_rdata  output  32  load data, valid while d_ready=1.
REQ-013 d_ready  output  1  one-cycle data-complete pulse.
REQ-014 ram_addr  output  32  shared RAM address.
REQ-015 ram_wdata  output  32  shared RAM write data.
REQ-016 ram_ren  output  1  RAM read strobe.
REQ-017 ram_wen  output  1  RAM write strobe.
REQ-018 ram_rdata  input  32  RAM read data.
REQ-019 ram_busy  input  1  RAM busy; access complete when low after issue.
REQ-020 err  output  1  sticky timeout flag.

Function
REQ-021 FSM states IDLE, ISSUE, WAIT, DONE; exactly one access in flight.
REQ-022 IDLE: if any request pending at clock edge, grant, latch address/wdata/kind (I-read, D-read, D-write) into internal registers, go ISSUE; else stay.
REQ-023 Grant: only one side pending -> that side; both pending -> side opposite last_grant (round-robin); last_grant updated on every grant.
REQ-024 d_ren and d_wen both 1 -> treated as D-write.
REQ-025 ISSUE (exactly one cycle): ram_addr/ram_wdata from latched registers; ram_ren=1 for reads, ram_wen=1 for writes; go WAIT.
REQ-026 ram_ren/ram_wen 0 in all states except ISSUE; ram_addr/ram_wdata hold latched values in ISSUE and WAIT, 0 in IDLE.
REQ-027 WAIT: 8-bit counter increments each cycle ram_busy=1; on edge with ram_busy=0, capture ram_rdata into i_rdata (I-read) or d_rdata (D-read), go DONE.
REQ-028 WAIT: counter reaching TIMEOUT with ram_busy still 1 -> set err, load 0 into granted rdata, go DONE.
REQ-029 DONE (one cycle): granted side's ready=1, other ready=0; go IDLE; counter cleared.
REQ-030 D-write completion: d_ready pulses; d_rdata unchanged.
REQ-031 i_rdata/d_rdata hold last captured value until next capture for same side.
REQ-032 Minimum latency: request high in IDLE cycle 0, ram_busy low -> ISSUE cycle 1, WAIT cycle 2, ready in cycle 3.
REQ-033 Request deasserted mid-access: access still completes, ready still pulses; inputs not re-sampled until IDLE.
REQ-034 Request still high in IDLE after its ready pulse is treated as a new request.
REQ-035 err sticky; cleared only by reset; arbiter continues to serve requests after timeout.

Reset
REQ-036 nrst=1 forces immediately, without clock: state IDLE, all outputs 0 (including ram strobes, ready, rdata, err), counter 0, last_grant = data (first tie goes to instruction).
REQ-037 Reset mid-access aborts it: no ready pulse, no capture; operation resumes in IDLE on the first edge after nrst falls.

Verification
REQ-038 i_req=1, i_addr=0x40, ram_busy=0, ram_rdata=0x00500093 -> ram_ren=1 with ram_addr=0x40 in cycle 1; i_ready=1, i_rdata=0x00500093 in cycle 3.
REQ-039 i_req and d_ren both 1 from reset -> instruction granted first, then D-read; both readies pulse once, in order i_ready then d_ready.
REQ-040 d_wen=1, d_addr=0x80, d_wdata=0xCAFEF00D, ram_busy high 4 cycles after issue -> ram_wen=1 exactly one cycle, d_ready 1 cycle after busy falls, d_rdata unchanged.
REQ-041 TIMEOUT=255, ram_busy held 1 -> after 255 WAIT cycles err=1, granted ready pulses with rdata=0; next request with ram_busy=0 completes normally, err stays 1.
REQ-042 nrst pulsed during WAIT of a D-read -> all outputs 0 immediately, no d_ready; held d_ren re-granted after reset release.
REQ-043 d_ren and d_wen both 1 -> ram_wen=1, ram_ren=0 in ISSUE.
